// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator: FSM states, funct3
// encodings, misalignment detection and load-result extension.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic funct3_ok(input logic is_load, input logic [2:0] funct3);
        if (is_load)
            return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        return funct3 inside {F3_B, F3_H, F3_W};
    endfunction

    // word is already shifted so the addressed byte sits in bits [7:0]
    function automatic logic [31:0] extend(input logic [2:0] funct3, input logic [31:0] word);
        case (funct3)
            F3_B:    return {{24{word[7]}}, word[7:0]};
            F3_H:    return {{16{word[15]}}, word[15:0]};
            F3_W:    return word;
            F3_BU:   return {24'h0, word[7:0]};
            F3_HU:   return {16'h0, word[15:0]};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data replication and load shift plus
// sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    always_comb begin
        wmask      = 4'b0000;
        wdata_lane = wdata;
        case (funct3[1:0])
            2'b00: begin
                wmask      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                wmask      = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            2'b10:   wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
    end

    assign rdata_ext = extend(funct3, rdata >> {addr_lo, 3'b000});

endmodule

// File: rtl/lsu_initiator.sv
// Load/store initiator: one execute-side access at a time onto a valid/ready
// memory bus. Define LSU_TIMEOUT_EN to add a response-wait timeout.
module lsu_initiator
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_wmask,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_rdata,
    input  logic        mem_rsp_err,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_rdata,
    output logic        wb_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    lsu_state_e  state;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        is_load_q;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_wmask;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        single_kind;
    logic        rsp_take;

    assign ex_ready    = (state == S_IDLE);
    assign single_kind = ex_is_load ^ ex_is_store;

    // Store lanes come from the live request in IDLE; load extension uses the captured access.
    assign al_funct3  = (state == S_IDLE) ? ex_funct3 : funct3_q;
    assign al_addr_lo = (state == S_IDLE) ? ex_addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .wdata      (ex_wdata),
        .rdata      (mem_rsp_rdata),
        .wmask      (al_wmask),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt;
    logic             stale;
    logic             timed_out;

    assign rsp_take  = mem_rsp_valid && !stale;
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign rsp_take  = mem_rsp_valid;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= S_IDLE;
            funct3_q      <= 3'b000;
            addr_lo_q     <= 2'b00;
            is_load_q     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= 32'h0;
            mem_req_wmask <= 4'b0000;
            mem_req_wdata <= 32'h0;
            mem_rsp_ready <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rdata      <= 32'h0;
            wb_err        <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt      <= '0;
            stale         <= 1'b0;
`endif
        end else begin
`ifdef LSU_TIMEOUT_EN
            // A timed-out response may still arrive in any state; swallow it once.
            if (stale && mem_rsp_valid && mem_rsp_ready) begin
                stale <= 1'b0;
                if (state != S_RESP)
                    mem_rsp_ready <= 1'b0;
            end
`endif
            case (state)
                S_IDLE: begin
                    if (ex_valid) begin
                        funct3_q  <= ex_funct3;
                        addr_lo_q <= ex_addr[1:0];
                        is_load_q <= ex_is_load;
                        if (!single_kind || misaligned(ex_funct3, ex_addr[1:0])) begin
                            wb_valid <= 1'b1;
                            wb_err   <= 1'b1;
                            wb_rdata <= 32'h0;
                            state    <= S_DONE;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_req_wen   <= ex_is_store;
                            mem_req_addr  <= {ex_addr[31:2], 2'b00};
                            mem_req_wmask <= ex_is_store ? al_wmask : 4'b0000;
                            mem_req_wdata <= ex_is_store ? al_wdata : 32'h0;
                            state         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_rsp_ready <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                        state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_take) begin
                        mem_rsp_ready <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_err        <= mem_rsp_err | !funct3_ok(is_load_q, funct3_q);
                        wb_rdata      <= is_load_q ? al_rdata : 32'h0;
                        state         <= S_DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (timed_out) begin
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b1;
                        wb_rdata <= 32'h0;
                        stale    <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        wb_err   <= 1'b0;
                        wb_rdata <= 32'h0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
